// File: rtl/cnt_initiator.sv
// cnt_initiator: active initiator for the 8-bit load/increment counter target.
// It accepts load / increment-burst requests and drives the target's
// cmd/data/addr pins every cycle. A reference count of the target is kept,
// and dout is checked two edges after each launch. One response is returned
// per transaction.
module cnt_initiator #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_cmd,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             cmd,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] dout,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, INC} state_t;

  // One launched command awaiting its check against dout.
  typedef struct packed {
    logic             valid;
    logic             last;
    logic [WIDTH-1:0] expected;
  } chk_t;

  state_t           state;
  logic [WIDTH-1:0] model;
  logic [LEN_W-1:0] burst;
  chk_t             launch_q;
  chk_t             apply_q;
  logic             chk_valid;
  logic             chk_last;
  logic             chk_bad;
  logic [WIDTH-1:0] chk_data;
  logic             txn_err;

  // Request FSM: launches one target command per edge and records it for checking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      cmd       <= 1'b0;
      data      <= '0;
      addr      <= '0;
      model     <= '0;
      burst     <= '0;
      launch_q  <= '0;
    end else begin
      // NOTE: these non-blocking defaults describe the idle hold (reload the
      // current count). A later assignment in the case below overrides them,
      // because the last non-blocking assignment in the block takes effect.
      cmd       <= 1'b0;
      data      <= model;
      req_ready <= 1'b1;
      launch_q  <= '{valid: 1'b1, last: 1'b0, expected: model};

      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr      <= req_addr;
            if (!req_cmd) begin
              state    <= LOAD;
              data     <= req_data;
              model    <= req_data;
              launch_q <= '{valid: 1'b1, last: 1'b1, expected: req_data};
            end else begin
              state    <= INC;
              cmd      <= 1'b1;
              burst    <= req_len;
              model    <= model + WIDTH'(1);
              launch_q <= '{valid: 1'b1, last: (req_len == '0),
                            expected: model + WIDTH'(1)};
            end
          end
        end
        LOAD: state <= IDLE;
        INC: begin
          if (burst == '0) begin
            state <= IDLE;
          end else begin
            req_ready <= 1'b0;
            cmd       <= 1'b1;
            burst     <= burst - LEN_W'(1);
            model     <= model + WIDTH'(1);
            launch_q  <= '{valid: 1'b1, last: (burst == LEN_W'(1)),
                          expected: model + WIDTH'(1)};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay stage covering the edge at which the target applies the command.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the check pipeline is reset so that commands in flight when reset
    // is asserted are discarded rather than compared after release.
    if (rst) apply_q <= '0;
    else     apply_q <= launch_q;
  end

  // Compare sampled dout with the expected count and keep the global error statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_valid <= 1'b0;
      chk_last  <= 1'b0;
      chk_bad   <= 1'b0;
      chk_data  <= '0;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      chk_valid <= apply_q.valid;
      chk_last  <= apply_q.last;
      chk_data  <= dout;
      chk_bad   <= apply_q.valid && (dout != apply_q.expected);
      if (apply_q.valid && (dout != apply_q.expected)) begin
        mismatch <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

  // Accumulate per-transaction errors and emit the response after the last check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      txn_err   <= 1'b0;
    end else begin
      rsp_valid <= chk_valid && chk_last;
      if (chk_valid) begin
        if (chk_last) begin
          rsp_data <= chk_data;
          rsp_err  <= txn_err | chk_bad;
          txn_err  <= 1'b0;
        end else begin
          txn_err  <= txn_err | chk_bad;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnt_initiator.sv
// Self-checking bench for cnt_initiator. It holds a behavioural counter target
// (with a stuck-at-zero override), a transaction-level reference count, and
// a queue of expected responses.
module tb_cnt_initiator;

  localparam int W = 8;
  localparam int L = 4;
  localparam int E = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_cmd = 1'b0;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] req_addr = '0;
  logic [L-1:0] req_len = '0;
  logic         cmd;
  logic [W-1:0] data;
  logic [W-1:0] addr;
  logic [W-1:0] dout;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic         mismatch;
  logic [E-1:0] err_cnt;

  always #5 clk = ~clk;

  cnt_initiator #(.WIDTH(W), .LEN_W(L), .ERR_W(E)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_data(req_data), .req_addr(req_addr), .req_len(req_len),
    .cmd(cmd), .data(data), .addr(addr), .dout(dout),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mismatch(mismatch), .err_cnt(err_cnt)
  );

  // Counter target: load on cmd=0, increment on cmd=1, reset with the initiator.
  logic [W-1:0] tcount;
  logic         stuck = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst)       tcount <= '0;
    else if (!cmd) tcount <= data;
    else           tcount <= tcount + 8'd1;
  end
  assign dout = stuck ? 8'h00 : tcount;

  typedef struct packed {
    logic [W-1:0] d;
    logic         e;
    int           c;
  } rsp_t;

  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  int           wrong_cnt = 0;
  logic [W-1:0] ref_count = '0;
  rsp_t         rsp_q[$];
  rsp_t         exp_q[$];
  logic         cmd_tr  [0:4095];
  logic [W-1:0] data_tr [0:4095];
  logic [W-1:0] addr_tr [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  // Trace the driven pins, collect responses, and count samples that a stuck target corrupts.
  always @(negedge clk) begin
    cmd_tr[cyc % 4096]  = cmd;
    data_tr[cyc % 4096] = data;
    addr_tr[cyc % 4096] = addr;
    if (!rst && rsp_valid) rsp_q.push_back('{d: rsp_data, e: rsp_err, c: cyc});
    if (!rst && stuck && tcount != 8'h00) wrong_cnt++;
  end

  // Present a request, wait (bounded) for acceptance, and update the reference model.
  task automatic send(input logic c, input logic [W-1:0] d, input logic [W-1:0] a,
                      input logic [L-1:0] l, input bit keep, output int acc);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = c; req_data = d; req_addr = a; req_len = l;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!keep) req_valid = 1'b0;
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL accept_timeout got=no_accept want=accept");
    end else begin
      if (!c) ref_count = d;
      else    ref_count = 8'(int'(ref_count) + int'(l) + 1);
      exp_q.push_back('{d: ref_count, e: 1'b0, c: acc + (c ? int'(l) : 0) + 3});
    end
  endtask

  // Bounded wait for the next collected response.
  task automatic get_rsp(output rsp_t r, output bit ok);
    ok = 1'b0;
    r  = '0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_q.size() > 0) begin
        r  = rsp_q.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [54:0] got;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {cmd, data, addr, req_ready, rsp_valid, rsp_data, rsp_err, mismatch, err_cnt};
    total++;
    if (got !== '0) begin
      bad++; $display("FAIL reset_values got=%h want=0", got);
    end
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL ready_before_edge got=%b want=0", req_ready);
    end
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL ready_first_edge got=%b want=1", req_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({cmd, data, rsp_valid, err_cnt} !== '0) begin
        bad++;
        $display("FAIL idle_hold got cmd=%b data=%h rsp_valid=%b err_cnt=%0d want 0/00/0/0",
                 cmd, data, rsp_valid, err_cnt);
      end
    end
  endtask

  task automatic test_load();
    int acc; rsp_t r, e; bit ok;
    logic [W-1:0] prev;
    prev = ref_count;
    send(1'b0, 8'h5A, 8'h3C, '0, 1'b0, acc);
    get_rsp(r, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || r !== e) begin
      bad++; $display("FAIL load_rsp got d=%h e=%b c=%0d want d=%h e=%b c=%0d", r.d, r.e, r.c, e.d, e.e, e.c);
    end
    repeat (2) @(negedge clk);
    total++;
    if ({cmd_tr[acc % 4096], data_tr[acc % 4096], addr_tr[acc % 4096], data_tr[(acc - 1) % 4096]}
        !== {1'b0, 8'h5A, 8'h3C, prev}) begin
      bad++;
      $display("FAIL load_drive got cmd=%b data=%h addr=%h prev=%h want 0/5a/3c/%h",
               cmd_tr[acc % 4096], data_tr[acc % 4096], addr_tr[acc % 4096], data_tr[(acc - 1) % 4096], prev);
    end
    total++;
    if (dout !== 8'h5A) begin
      bad++; $display("FAIL load_target got=%h want=5a", dout);
    end
  endtask

  task automatic test_wrap();
    int a0, b; rsp_t r, e; bit ok;
    send(1'b0, 8'hFE, 8'h21, '0, 1'b0, a0);
    repeat (2) @(posedge clk);
    send(1'b1, 8'h00, 8'h22, 4'd3, 1'b0, b);
    for (int i = 0; i < 2; i++) begin
      get_rsp(r, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || r !== e) begin
        bad++; $display("FAIL wrap_rsp%0d got d=%h e=%b c=%0d want d=%h e=%b c=%0d", i, r.d, r.e, r.c, e.d, e.e, e.c);
      end
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({cmd_tr[(b + k) % 4096], data_tr[(b + k) % 4096]} !== {1'b1, 8'(8'hFE + k)}) begin
        bad++;
        $display("FAIL wrap_burst%0d got cmd=%b data=%h want 1/%h",
                 k, cmd_tr[(b + k) % 4096], data_tr[(b + k) % 4096], 8'(8'hFE + k));
      end
    end
    total++;
    if (cmd_tr[(b + 4) % 4096] !== 1'b0 || dout !== 8'h02) begin
      bad++; $display("FAIL wrap_end got cmd=%b dout=%h want 0/02", cmd_tr[(b + 4) % 4096], dout);
    end
  endtask

  task automatic test_stuck();
    int acc; rsp_t r, e; bit ok;
    @(posedge clk); #2; stuck = 1'b1;
    send(1'b0, 8'h33, 8'h11, '0, 1'b0, acc);
    get_rsp(r, ok);
    e = exp_q.pop_front();
    e.d = 8'h00;
    e.e = 1'b1;
    total++;
    if (!ok || r !== e) begin
      bad++; $display("FAIL stuck_rsp got d=%h e=%b c=%0d want d=%h e=%b c=%0d", r.d, r.e, r.c, e.d, e.e, e.c);
    end
    total++;
    if (mismatch !== 1'b1) begin
      bad++; $display("FAIL stuck_sticky got=%b want=1", mismatch);
    end
    repeat (3) @(posedge clk);
    #2; stuck = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (err_cnt !== E'(wrong_cnt)) begin
      bad++; $display("FAIL stuck_err_cnt got=%0d want=%0d", err_cnt, wrong_cnt);
    end
    // Idle-hold mismatches after the 0x33 response belong to the next transaction.
    send(1'b0, 8'h44, 8'h12, '0, 1'b0, acc);
    get_rsp(r, ok);
    e = exp_q.pop_front();
    e.e = 1'b1;
    total++;
    if (!ok || r !== e) begin
      bad++; $display("FAIL carry_rsp got d=%h e=%b c=%0d want d=%h e=%b c=%0d", r.d, r.e, r.c, e.d, e.e, e.c);
    end
    total++;
    if (err_cnt !== E'(wrong_cnt)) begin
      bad++; $display("FAIL carry_err_cnt got=%0d want=%0d", err_cnt, wrong_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, a3; rsp_t r, e; bit ok;
    send(1'b0, 8'h10, 8'h01, '0, 1'b1, a1);
    send(1'b1, 8'h00, 8'h02, 4'd0, 1'b1, a2);
    send(1'b0, 8'h80, 8'h03, '0, 1'b0, a3);
    total++;
    if (a2 - a1 != 2 || a3 - a2 != 2) begin
      bad++; $display("FAIL b2b_spacing got=%0d,%0d want=2,2", a2 - a1, a3 - a2);
    end
    for (int i = 0; i < 3; i++) begin
      get_rsp(r, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || r !== e) begin
        bad++; $display("FAIL b2b_rsp%0d got d=%h e=%b c=%0d want d=%h e=%b c=%0d", i, r.d, r.e, r.c, e.d, e.e, e.c);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc; rsp_t r, e; bit ok;
    logic [54:0] got;
    send(1'b1, 8'h00, 8'h55, 4'd15, 1'b0, acc);
    repeat (5) @(posedge clk);
    #2; rst = 1'b1; #1;
    got = {cmd, data, addr, req_ready, rsp_valid, rsp_data, rsp_err, mismatch, err_cnt};
    total++;
    if (got !== '0) begin
      bad++; $display("FAIL mid_reset_values got=%h want=0", got);
    end
    exp_q.delete();
    ref_count = '0;
    wrong_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (25) @(negedge clk);
    total++;
    if (rsp_q.size() != 0) begin
      bad++; $display("FAIL mid_reset_no_rsp got=%0d want=0", rsp_q.size());
    end
    rsp_q.delete();
    send(1'b0, 8'h07, 8'h08, '0, 1'b0, acc);
    get_rsp(r, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || r !== e) begin
      bad++; $display("FAIL mid_reset_rsp got d=%h e=%b c=%0d want d=%h e=%b c=%0d", r.d, r.e, r.c, e.d, e.e, e.c);
    end
  endtask

  task automatic test_random();
    int acc [16];
    logic c_v [16];
    logic [W-1:0] a_v [16];
    rsp_t r, e; bit ok; int n;
    for (int i = 0; i < 16; i++) begin
      logic keep;
      c_v[i] = 1'($urandom_range(0, 1));
      a_v[i] = 8'($urandom);
      keep   = 1'($urandom_range(0, 1));
      send(c_v[i], 8'($urandom), a_v[i], 4'($urandom_range(0, 7)), keep, acc[i]);
      if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    req_valid = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      get_rsp(r, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || r !== e) begin
        bad++; $display("FAIL rand_rsp%0d got d=%h e=%b c=%0d want d=%h e=%b c=%0d", i, r.d, r.e, r.c, e.d, e.e, e.c);
      end
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({cmd_tr[acc[i] % 4096], addr_tr[acc[i] % 4096]} !== {c_v[i], a_v[i]}) begin
        bad++;
        $display("FAIL rand_drive%0d got cmd=%b addr=%h want %b/%h",
                 i, cmd_tr[acc[i] % 4096], addr_tr[acc[i] % 4096], c_v[i], a_v[i]);
      end
    end
    total++;
    if (err_cnt !== '0 || mismatch !== 1'b0 || dout !== ref_count) begin
      bad++;
      $display("FAIL rand_final got err_cnt=%0d mismatch=%b dout=%h want 0/0/%h",
               err_cnt, mismatch, dout, ref_count);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_wrap();
    test_stuck();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cnt_initiator.md
Name: cnt_initiator

Overview:
- Active initiator for the 8-bit load/increment counter target (inputs `cmd`/`data`/`addr`, output `dout`).
- Accepts transaction requests on a valid/ready interface and drives the target's `cmd`/`data`/`addr` pins cycle by cycle.
- Keeps a reference model of the target's count and checks `dout` against it every cycle.
- Returns one response per transaction: final count plus error flag. Sits between sequencer-side stimulus logic and the counter target.

Parameters:
- WIDTH, 8, data/addr/count width
- LEN_W, 4, increment-burst length field width (burst = req_len+1, 1..2^LEN_W)
- ERR_W, 16, width of saturating error counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  initiator can accept request
- req_cmd  in  1  0 = load req_data, 1 = increment burst
- req_data  in  WIDTH  load value (ignored for increment)
- req_addr  in  WIDTH  address driven to target for whole transaction
- req_len  in  LEN_W  increment count minus 1 (ignored for load)
- cmd  out  1  to target
- data  out  WIDTH  to target
- addr  out  WIDTH  to target
- dout  in  WIDTH  from target
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  WIDTH  dout sampled at last check of transaction
- rsp_err  out  1  any mismatch during that transaction
- mismatch  out  1  sticky, any mismatch since reset
- err_cnt  out  ERR_W  total mismatching checks, saturating

Behaviour:
- Reset values: cmd=0, data=0, addr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, mismatch=0, err_cnt=0. Model count=0, check pipeline cleared, FSM=IDLE.
- req_ready rises on the first clock edge after rst deasserts.
- Target has no enable, so a command is driven every cycle. In IDLE the block drives cmd=0, data=model count, addr=last addr. This hold-by-reload keeps the target static.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture the request. Go to LOAD if req_cmd=0, else INC with burst counter=req_len.
  - LOAD: 1 cycle. cmd=0, data=req_data, addr=req_addr, model<=req_data. Then IDLE.
  - INC: cmd=1, data=model, addr=req_addr, model<=model+1 each cycle. Stays req_len+1 cycles, burst counter decrements to 0, then IDLE.
  - req_ready=0 in LOAD/INC, so back-to-back requests cost one IDLE cycle between them.
- All target-side outputs are registered; no combinational path from req_* to cmd/data/addr.
- Arithmetic: model increments modulo 2^WIDTH (0xFF+1 = 0x00).
- Check pipeline:
  - Every cycle a command is launched, push an entry {expected=post-command model value, valid, last}.
  - last=1 on a LOAD cycle or the final INC cycle.
  - Entries are compared with dout two rising edges after the launch edge: one edge for the target to apply, one for the sample.
  - The first launch after reset is marked valid; no checks happen before it.
- Per check:
  - On mismatch: err_cnt++ (saturates at all-ones), mismatch<=1, txn sticky error set.
  - IDLE-hold entries are checked too (last=0).
- Response:
  - When a checked entry has last=1, on the next edge: rsp_valid=1 for one cycle, rsp_data=sampled dout, rsp_err=txn sticky OR this check's mismatch.
  - The txn sticky then clears.
  - Checks from the next transaction may overlap the response of the previous one. Ordering is preserved and stickies are not merged.
  - IDLE-hold mismatches between transactions count toward the next transaction's rsp_err.
- Reset mid-transaction: immediate return to reset values. In-flight checks are discarded and no response is produced. The target is reset by the same event.

Test Plan:
- Reset then idle 10 cycles -> cmd=0, data=0 every cycle, err_cnt=0, no rsp_valid, req_ready=1 from first edge after reset.
- Load 0x5A -> exactly 1 cycle cmd=0/data=0x5A, rsp_valid 3 cycles after acceptance edge with rsp_data=0x5A, rsp_err=0, target holds 0x5A afterwards.
- Load 0xFE then increment req_len=3 -> cmd=1 for 4 consecutive cycles, count wraps 0xFE->0xFF->0x00->0x01->0x02, responses 0xFE and 0x02, rsp_err=0.
- Force dout to 0x00 (stuck target) during load 0x33 -> rsp_err=1, mismatch=1, err_cnt increments once per wrong check including idle-hold checks.
- Back-to-back requests with req_valid held high (load 0x10, increment len=0, load 0x80) -> one IDLE cycle between each, responses 0x10, 0x11, 0x80 in order.
- Assert rst during an INC burst of len=15 -> outputs return to reset values asynchronously, no rsp_valid; a new load 0x07 after release passes with rsp_err=0.
